// File: rtl/bus_select_arbiter_pkg.sv
// bus_select_arbiter_pkg: shared FSM encoding, source count, index width and one-hot-to-index helper
// No ports; imported by rr_pick and bus_select_arbiter.
package bus_select_arbiter_pkg;
    localparam int N_SRC = 4;
    localparam int IDX_W = 2;
    typedef enum logic [1:0] {ST_IDLE, ST_OWN, ST_TURN} state_t;
    function automatic logic [IDX_W-1:0] onehot_idx(input logic [N_SRC-1:0] v);
        return {v[3] | v[2], v[3] | v[1]};
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotating-priority picker, scanning upward from ptr+1
// Ports: req  - request vector
//        ptr  - index of the last winner
//        win  - one-hot winner (all-zero when nothing requests)
//        valid - high when any request is present
module rr_pick
    import bus_select_arbiter_pkg::*;
(
    input  logic [N_SRC-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_SRC-1:0] win,
    output logic             valid
);
    logic [IDX_W-1:0] idx;
    // Scan from farthest to nearest so the nearest set bit after ptr overwrites last.
    always_comb begin
        win = '0;
        idx = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) win = N_SRC'(1) << idx;
        end
    end
    assign valid = |req;
endmodule

// File: rtl/bus_select_arbiter.sv
// bus_select_arbiter: round-robin owner select for a 4:1 tristate bus with break-before-make turnaround
// Ports: clk     - rising-edge clock
//        rst_n   - asynchronous active-low reset, released synchronously
//        REQ     - per-source level request
//        LAST    - per-source release strobe, honoured only for the owner
//        GNT     - registered one-hot bus enable
//        GNT_ID  - registered owner index, 0 when idle
//        BUSY    - registered, high while GNT is non-zero
//        TIMEOUT - one-cycle pulse on forced release
// Optional: define ARB_TIMEOUT_EN to build the HOLD_MAX hold counter and TIMEOUT pulse.
module bus_select_arbiter
    import bus_select_arbiter_pkg::*;
#(
    parameter int TURN_CYC = 1,
    parameter int HOLD_MAX = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] REQ,
    input  logic [N_SRC-1:0] LAST,
    output logic [N_SRC-1:0] GNT,
    output logic [IDX_W-1:0] GNT_ID,
    output logic             BUSY,
    output logic             TIMEOUT
);
    state_t           state_q, state_d;
    logic [N_SRC-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] gnt_id_q, gnt_id_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [3:0]       turn_q, turn_d;
    logic             busy_q, busy_d;
    logic             armed_q;
    logic [N_SRC-1:0] win;
    logic             win_valid;
    logic             can_arb;
    logic             drop;
    logic             force_rel;
    rr_pick u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .win   (win),
        .valid (win_valid)
    );
`ifdef ARB_TIMEOUT_EN
    logic [9:0] hold_q, hold_d;
    logic       timeout_q, timeout_d;
    // hold_q counts completed OWN cycles; it rests at 0 outside OWN, so every new grant starts from 0.
    assign force_rel = state_q == ST_OWN && hold_q == 10'(HOLD_MAX - 1);
    always_comb begin
        hold_d    = state_q == ST_OWN ? hold_q + 10'd1 : '0;
        timeout_d = force_rel && !drop;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
        end
    end
    assign TIMEOUT = timeout_q;
`else
    logic unused_hold_max;
    assign unused_hold_max = HOLD_MAX > 0;
    assign force_rel       = 1'b0;
    assign TIMEOUT         = 1'b0;
`endif
    // armed_q holds off arbitration for the first edge after reset release.
    assign drop    = state_q == ST_OWN && (!REQ[gnt_id_q] || LAST[gnt_id_q]);
    assign can_arb = armed_q && (state_q == ST_IDLE || (state_q == ST_TURN && turn_q == '0));
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        ptr_d    = ptr_q;
        turn_d   = turn_q == '0 ? '0 : turn_q - 4'd1;
        if (drop || force_rel) begin
            state_d  = ST_TURN;
            gnt_d    = '0;
            gnt_id_d = '0;
            turn_d   = 4'(TURN_CYC - 1);
        end else if (can_arb && win_valid) begin
            state_d  = ST_OWN;
            gnt_d    = win;
            gnt_id_d = onehot_idx(win);
            ptr_d    = onehot_idx(win);
        end else if (can_arb) begin
            state_d  = ST_IDLE;
        end
        busy_d = |gnt_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            ptr_q    <= IDX_W'(N_SRC - 1);
            turn_q   <= '0;
            busy_q   <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            ptr_q    <= ptr_d;
            turn_q   <= turn_d;
            busy_q   <= busy_d;
            armed_q  <= 1'b1;
        end
    end
    assign GNT    = gnt_q;
    assign GNT_ID = gnt_id_q;
    assign BUSY   = busy_q;
endmodule

// File: tb/tb_bus_select_arbiter.sv
// tb_bus_select_arbiter: directed scoreboard bench for bus_select_arbiter
module tb_bus_select_arbiter;
    localparam int TC = 2;
    localparam int HM = 8;
    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] id;
        logic       busy;
        logic       to;
    } obs_t;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] last = '0;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;
    logic [3:0] prev_gnt = '0;
    obs_t       exp_q[$];
    int         total = 0;
    int         passed = 0;
    always #5 clk = ~clk;
    bus_select_arbiter #(.TURN_CYC(TC), .HOLD_MAX(HM)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .REQ     (req),
        .LAST    (last),
        .GNT     (gnt),
        .GNT_ID  (gnt_id),
        .BUSY    (busy),
        .TIMEOUT (timeout)
    );
    function automatic obs_t mk(input logic [3:0] g, input logic t);
        obs_t o;
        o.gnt = g;
        o.id  = '0;
        for (int i = 0; i < 4; i++) if (g[i]) o.id = 2'(i);
        o.busy = |g;
        o.to   = t;
        return o;
    endfunction
    task automatic check(input string tag);
        obs_t a, e;
        a = {gnt, gnt_id, busy, timeout};
        e = exp_q.pop_front();
        total++;
        assert (a === e) passed++;
        else $error("FAIL %s: observed gnt=%b id=%0d busy=%b to=%b, expected gnt=%b id=%0d busy=%b to=%b",
                    tag, a.gnt, a.id, a.busy, a.to, e.gnt, e.id, e.busy, e.to);
    endtask
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l, input logic [3:0] g, input logic t);
        req  = r;
        last = l;
        exp_q.push_back(mk(g, t));
        @(posedge clk);
        #1;
        check(tag);
    endtask
    task automatic now_check(input string tag);
        exp_q.push_back(mk(4'b0000, 1'b0));
        check(tag);
    endtask
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        now_check({tag, "_async"});
        step({tag, "_hold"}, req, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
    endtask
    // Every cycle: one-hot-or-zero, and no direct owner-to-owner handover.
    always @(negedge clk) begin
        total++;
        assert ($onehot0(gnt) && (prev_gnt == 4'd0 || gnt == 4'd0 || gnt == prev_gnt)) passed++;
        else $error("FAIL onehot_handover: gnt=%b prev=%b", gnt, prev_gnt);
        prev_gnt = gnt;
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    initial begin
        logic [3:0] g, nx;
        @(posedge clk);
        #1;
        now_check("reset_state");
        step("reset_hold", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        // Single requester, first grant on the second edge after release.
        step("sr_arm",   4'b0100, 4'b0000, 4'b0000, 1'b0);
        step("sr_grant", 4'b0100, 4'b0000, 4'b0100, 1'b0);
        step("sr_hold",  4'b0100, 4'b0000, 4'b0100, 1'b0);
        step("sr_drop",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < TC; k++) step("sr_turn", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        step("sr_idle",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        // All requesting, each owner releases with LAST in its third cycle.
        do_reset("rst_rr");
        step("rr_arm",   4'b1111, 4'b0000, 4'b0000, 1'b0);
        step("rr_first", 4'b1111, 4'b0000, 4'b0001, 1'b0);
        for (int i = 0; i < 4; i++) begin
            g  = 4'b0001 << i;
            nx = 4'b0001 << ((i + 1) % 4);
            step("rr_hold1", 4'b1111, 4'b0000, g, 1'b0);
            step("rr_hold2", 4'b1111, 4'b0000, g, 1'b0);
            step("rr_last",  4'b1111, g,       4'b0000, 1'b0);
            for (int k = 0; k < TC - 1; k++) step("rr_turn", 4'b1111, 4'b0000, 4'b0000, 1'b0);
            step("rr_next",  4'b1111, 4'b0000, nx, 1'b0);
        end
        step("rr_drop", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < TC; k++) step("rr_quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Owner 1 with noise on the other sources.
        step("nz_grant", 4'b0010, 4'b0000, 4'b0010, 1'b0);
        step("nz_n1",    4'b1111, 4'b0101, 4'b0010, 1'b0);
        step("nz_n2",    4'b0110, 4'b0101, 4'b0010, 1'b0);
        step("nz_n3",    4'b1010, 4'b0101, 4'b0010, 1'b0);
        step("nz_n4",    4'b0011, 4'b1101, 4'b0010, 1'b0);
        step("nz_last",  4'b0010, 4'b0010, 4'b0000, 1'b0);
        for (int k = 0; k < TC; k++) step("nz_quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Reset in the middle of a grant.
        step("rm_grant", 4'b1000, 4'b0000, 4'b1000, 1'b0);
        step("rm_hold",  4'b1000, 4'b0000, 4'b1000, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        now_check("rm_async");
        step("rm_in_reset", 4'b1001, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b1;
        step("rm_arm",   4'b1001, 4'b0000, 4'b0000, 1'b0);
        step("rm_first", 4'b1001, 4'b0000, 4'b0001, 1'b0);
        step("rm_drop",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < TC; k++) step("rm_quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);
`ifdef ARB_TIMEOUT_EN
        // Owner never releases; hold limit forces the handover.
        do_reset("rst_to");
        step("to_arm",   4'b0011, 4'b0000, 4'b0000, 1'b0);
        step("to_grant", 4'b0011, 4'b0000, 4'b0001, 1'b0);
        for (int k = 1; k < HM; k++) step("to_hold", 4'b0011, 4'b0000, 4'b0001, 1'b0);
        step("to_fire",  4'b0011, 4'b0000, 4'b0000, 1'b1);
        for (int k = 0; k < TC - 1; k++) step("to_turn", 4'b0011, 4'b0000, 4'b0000, 1'b0);
        step("to_next",  4'b0011, 4'b0000, 4'b0010, 1'b0);
        step("to_drop",  4'b0000, 4'b0000, 4'b0000, 1'b0);
        for (int k = 0; k < TC; k++) step("to_quiet", 4'b0000, 4'b0000, 4'b0000, 1'b0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bus_select_arbiter.md
BUS_SELECT_ARBITER -- requirements
Module: bus_select_arbiter

Interface
REQ-001 Parameter TURN_CYC, default 1: bus-turnaround cycles with all grants low between owners; legal range 1..15.
REQ-002 Parameter HOLD_MAX, default 64: maximum consecutive grant cycles per owner; used only when ARB_TIMEOUT_EN is defined; legal range 2..1023.
REQ-003 Port clk, input, 1: single rising-edge clock.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port REQ, input, 4: per-source request, level, held until served.
REQ-006 Port LAST, input, 4: per-source release strobe, qualified only for the current owner.
REQ-007 Port GNT, output, 4: registered one-hot tristate-enable vector to the downstream 4:1 bus mux, bit i enables source i.
REQ-008 Port GNT_ID, output, 2: binary index of the current owner, 0 when GNT is all-zero.
REQ-009 Port BUSY, output, 1: high whenever GNT is non-zero.
REQ-010 Port TIMEOUT, output, 1: one-cycle pulse on forced release; constant 0 when ARB_TIMEOUT_EN is undefined.

Function
REQ-011 GNT SHALL be one-hot or all-zero on every cycle, including across reset.
REQ-012 The FSM SHALL have three states: IDLE (GNT=0), OWN (GNT one-hot), TURN (GNT=0).
REQ-013 IDLE: if REQ!=0, the winner SHALL be the first set bit scanning upward from (ptr+1) mod 4; GNT SHALL assert on the next edge; state goes to OWN. Request-to-grant latency is 1 cycle.
REQ-014 On each grant, ptr SHALL load the winner index.
REQ-015 OWN: the grant SHALL hold while REQ[owner]=1 and LAST[owner]=0.
REQ-016 OWN: if REQ[owner]=0 or LAST[owner]=1, GNT SHALL clear on the next edge and the FSM SHALL enter TURN.
REQ-017 LAST and REQ bits of non-owners SHALL not affect the current grant.
REQ-018 TURN SHALL last exactly TURN_CYC cycles with GNT=0.
REQ-019 In the final TURN cycle the arbiter SHALL arbitrate as in IDLE. With a pending request, the next grant is driven on the following edge; otherwise the FSM enters IDLE.
REQ-020 A new owner SHALL never be granted on the cycle directly after a previous grant; there is no make-before-break.
REQ-021 Simultaneous requests SHALL be resolved round-robin: a source requesting continuously is served within 4 grants.
REQ-022 GNT_ID and BUSY SHALL be registered consistently with GNT; they SHALL not be decoded combinationally from REQ.

Reset
REQ-023 Asserting rst_n low SHALL force GNT=0, GNT_ID=0, BUSY=0, TIMEOUT=0, state=IDLE, ptr=3, and hold counter=0 immediately, without waiting for clk.
REQ-024 Reset asserted mid-grant SHALL drop GNT the same instant; after release, the first arbitration SHALL favour source 0.
REQ-025 Reset deassertion SHALL be taken synchronously; the first grant appears no earlier than the second rising edge after rst_n rises.

Configuration
REQ-026 With ARB_TIMEOUT_EN defined, a hold counter SHALL count OWN cycles. When it reaches HOLD_MAX, the FSM SHALL force release as in REQ-016 and pulse TIMEOUT for 1 cycle. The counter SHALL clear on each new grant.
REQ-027 Without ARB_TIMEOUT_EN, no hold counter SHALL be built, HOLD_MAX SHALL be ignored, and TIMEOUT SHALL be tied to 0.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE/OWN/TURN), the source-count constant (4), and the index width (2).
REQ-029 A sub-module rr_pick SHALL provide the combinational rotating-priority picker. Its inputs are REQ and ptr; its outputs are a one-hot winner and a valid flag. All state SHALL stay in the top.

Verification
REQ-030 Single request: after reset, REQ=0100 -> GNT=0100 and GNT_ID=2 one cycle later. Then drop REQ -> GNT=0000 next cycle, TURN for TURN_CYC cycles, then IDLE.
REQ-031 All requesting: REQ=1111 held, each owner pulses LAST after 3 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with GNT=0000 for TURN_CYC cycles between each grant.
REQ-032 Non-owner noise: owner 1, LAST=0101 and REQ toggling on bits 0, 2, 3 -> GNT stays 0010.
REQ-033 Reset mid-grant: GNT=1000, pull rst_n low between edges -> GNT=0000 immediately. After release with REQ=1001 -> GNT=0001.
REQ-034 Timeout with ARB_TIMEOUT_EN and HOLD_MAX=8: REQ=0011 held, no LAST -> owner 0 released after 8 grant cycles, TIMEOUT pulses once, then GNT=0010 after the turnaround.
REQ-035 All runs: an assertion checks that GNT is one-hot or all-zero on every cycle, and that two different owners never appear on consecutive cycles.
